// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and widths for the instruction fetch unit.
//                - state_t       : fetch control state (RUN / HALT)
//                - fetch_entry_t : one buffered fetch result {pc, instr}
//                - c_INSTR_W     : instruction width
//                - c_ADDR_W      : byte-address width
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam int c_INSTR_W = 32;
   localparam int c_ADDR_W  = 32;

   // RUN fetches sequentially; HALT is entered on any fetch fault and is
   // only left through reset.
   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   typedef struct packed {
      logic [c_ADDR_W-1:0]  pc;
      logic [c_INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Two-entry register FIFO holding fetched {pc, instr} pairs.
//                Ports:
//                  clk, rst   - clock, asynchronous active-high reset
//                  flush      - empty the FIFO (wins over push and pop)
//                  push       - write push_data at the tail
//                  push_data  - entry to write
//                  pop        - drop the head entry
//                  head       - current head entry (valid when count != 0)
//                  count      - number of stored entries (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   // Storage is two discrete registers selected by one-bit pointers.
   fetch_entry_t r_slot0;
   fetch_entry_t r_slot1;
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;

   logic         w_do_pop;
   logic         w_do_push;

   // A pop is only honoured when there is something to pop; a push is only
   // honoured when a slot is free or is being freed in the same cycle. When
   // full, the write slot equals the read slot: the head leaves at this edge
   // while the new entry lands behind the remaining one, so order is kept.
   assign w_do_pop  = pop & (r_count != 2'd0);
   assign w_do_push = push & ((r_count != 2'(DEPTH)) | w_do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_slot0  <= '0;
         r_slot1  <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_do_push) begin
            if (r_wr_ptr == 1'b0) begin
               r_slot0 <= push_data;
            end else begin
               r_slot1 <= push_data;
            end
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_do_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign head  = r_rd_ptr ? r_slot1 : r_slot0;
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Sequential instruction fetch with a 2-entry output buffer,
//                redirect handling and sticky fault reporting.
//                Ports:
//                  clk, rst        - clock, asynchronous active-high reset
//                  imem_addr       - byte address to instruction memory
//                  imem_instr      - same-cycle instruction word
//                  redirect_valid  - one-cycle branch/jump redirect request
//                  redirect_pc     - redirect target byte address
//                  out_valid       - out_pc/out_instr hold an instruction
//                  out_ready       - consumer accepts the instruction
//                  out_pc          - byte address of out_instr
//                  out_instr       - fetched instruction
//                  fault           - sticky fetch fault
//                  fault_pc        - address that caused the fault
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [c_ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
   parameter int                  MEM_DEPTH = 256,
   parameter int                  BUF_DEPTH = 2
)
(
   input  logic                 clk,
   input  logic                 rst,
   output logic [c_ADDR_W-1:0]  imem_addr,
   input  logic [c_INSTR_W-1:0] imem_instr,
   input  logic                 redirect_valid,
   input  logic [c_ADDR_W-1:0]  redirect_pc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [c_ADDR_W-1:0]  out_pc,
   output logic [c_INSTR_W-1:0] out_instr,
   output logic                 fault,
   output logic [c_ADDR_W-1:0]  fault_pc
);

   // Highest legal word-aligned byte address in instruction memory.
   localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(MEM_DEPTH * 4 - 4);

   state_t              r_state;
   logic [c_ADDR_W-1:0] r_fetch_pc;
   logic                r_fault;
   logic [c_ADDR_W-1:0] r_fault_pc;

   logic                w_run;
   logic                w_range_err;
   logic                w_misaligned;
   logic                w_flush;
   logic                w_pop;
   logic                w_push;
   logic [1:0]          w_count;
   fetch_entry_t        w_push_data;
   fetch_entry_t        w_head;

   assign w_run        = (r_state == RUN);
   assign w_range_err  = (r_fetch_pc > c_LAST_ADDR);
   assign w_misaligned = (redirect_pc[1:0] != 2'b00);

   // Redirects only take effect while running; in HALT they are ignored.
   assign w_flush = w_run & redirect_valid;
   assign w_pop   = out_valid & out_ready;

   // A fetch is written to the buffer when there is room now, or room is
   // being made by a pop this cycle. A redirect or an out-of-range address
   // suppresses it.
   assign w_push = w_run & ~redirect_valid & ~w_range_err
                   & ((w_count < 2'(BUF_DEPTH)) | w_pop);

   assign w_push_data.pc    = r_fetch_pc;
   assign w_push_data.instr = imem_instr;

   fetch_fifo #(
      .DEPTH     (BUF_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (w_flush),
      .push      (w_push),
      .push_data (w_push_data),
      .pop       (w_pop),
      .head      (w_head),
      .count     (w_count)
   );

   // Control state, fetch pointer and fault reporting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= RUN;
         r_fetch_pc <= RESET_PC;
         r_fault    <= 1'b0;
         r_fault_pc <= '0;
      end else begin
         case (r_state)
            RUN: begin
               if (redirect_valid) begin
                  r_fetch_pc <= redirect_pc;
                  if (w_misaligned) begin
                     r_state    <= HALT;
                     r_fault    <= 1'b1;
                     r_fault_pc <= redirect_pc;
                  end
               end else if (w_range_err) begin
                  r_state    <= HALT;
                  r_fault    <= 1'b1;
                  r_fault_pc <= r_fetch_pc;
               end else if (w_push) begin
                  r_fetch_pc <= r_fetch_pc + 32'd4;
               end
            end
            HALT: begin
               // Fetching has stopped; only the buffer keeps draining.
               r_fault <= 1'b1;
            end
            default: begin
               r_state <= HALT;
               r_fault <= 1'b1;
            end
         endcase
      end
   end

   assign imem_addr = r_fetch_pc;
   assign out_valid = (w_count != 2'd0);
   assign out_pc    = w_head.pc;
   assign out_instr = w_head.instr;
   assign fault     = r_fault;
   assign fault_pc  = r_fault_pc;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter MEM_DEPTH, default 256, is the instruction-memory depth in 32-bit words; the legal byte range is 0 .. MEM_DEPTH*4-4.
REQ-003 Parameter BUF_DEPTH, default 2, is the fetch-buffer depth in entries; the block SHALL support only the value 2.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 imem_addr  output  32  byte address to the instruction memory; the memory read is combinational, with the word returned in the same cycle.
REQ-007 imem_instr  input  32  instruction word for imem_addr.
REQ-008 redirect_valid  input  1  branch/jump redirect request; single-cycle qualifier.
REQ-009 redirect_pc  input  32  redirect target byte address.
REQ-010 out_valid  output  1  {out_pc, out_instr} holds a valid instruction.
REQ-011 out_ready  input  1  consumer accepts the instruction this cycle.
REQ-012 out_pc  output  32  byte address of out_instr.
REQ-013 out_instr  output  32  fetched instruction.
REQ-014 fault  output  1  sticky fetch fault.
REQ-015 fault_pc  output  32  address that caused the fault.

Function
REQ-016 The block SHALL keep a fetch_pc register, a 2-entry FIFO of {pc, instr}, and a state register with states RUN and HALT.
REQ-017 imem_addr SHALL equal fetch_pc in every cycle.
REQ-018 pop = out_valid & out_ready.
REQ-019 push = (state==RUN) & ~redirect_valid & ~range_err & (count<2 | pop).
REQ-020 On push, the FIFO SHALL capture {fetch_pc, imem_instr} and fetch_pc SHALL advance by 4.
REQ-021 range_err is asserted when fetch_pc > MEM_DEPTH*4-4; in RUN, range_err SHALL move the state to HALT, set fault, and load fault_pc=fetch_pc with no push.
REQ-022 Simultaneous push and pop with count==2 SHALL keep count at 2 and preserve order.
REQ-023 out_valid SHALL equal (count!=0); out_pc and out_instr SHALL be the FIFO head.
REQ-024 While out_valid is high and out_ready is low, out_pc and out_instr SHALL be held stable.
REQ-025 redirect_valid has priority over push, pop and range_err in the same cycle; it SHALL:
  - flush the FIFO (count=0);
  - load fetch_pc=redirect_pc.
REQ-026 Misaligned redirect (redirect_pc[1:0]!=0): the FIFO SHALL be flushed, the state SHALL go to HALT, fault SHALL be set, and fault_pc SHALL be loaded with redirect_pc.
REQ-027 Redirect latency: redirect at cycle N -> out_valid=0 in N+1, memory read of redirect_pc in N+1, out_valid=1 with out_pc=redirect_pc in N+2.
REQ-028 In HALT, the block SHALL:
  - not push;
  - continue to drain the FIFO through pop;
  - ignore redirect_valid;
  - hold fault high.
  Only reset exits HALT.
REQ-029 fetch_pc arithmetic is 32-bit modulo; wrap-around is unreachable, because range_err fires first.

Reset
REQ-030 On rst assertion, immediately and asynchronously, the block SHALL set: state=RUN, fetch_pc=RESET_PC, count=0, FIFO pointers=0, fault=0, fault_pc=0.
REQ-031 After reset: out_valid=0, imem_addr=RESET_PC.
REQ-032 Reset asserted mid-operation SHALL discard all buffered instructions and any pending redirect.
REQ-033 The first cycle after rst deasserts SHALL fetch RESET_PC; out_valid SHALL rise in the following cycle.

Structure
REQ-034 A shared package fetch_pkg SHALL hold the state enum (RUN, HALT), the instruction width 32, and the address width 32.
REQ-035 The FIFO SHALL be a sub-module fetch_fifo (2-entry, with flush, push, pop, count outputs).
REQ-036 The FIFO storage SHALL be registers; fetch_unit SHALL contain no memory array.

Verification
REQ-037 Reset release, out_ready=1, memory word[i]=i+0x100 -> out_pc 0,4,8,... on consecutive cycles from cycle 2; out_instr=0x100,0x101,...
REQ-038 out_ready=0 for 5 cycles after the first valid -> count saturates at 2; imem_addr holds 8; no loss or duplication after release.
REQ-039 Redirect to 0x40 while the FIFO is full and out_ready=1 in the same cycle -> next cycle out_valid=0; the cycle after, out_pc=0x40 and out_instr=word[16].
REQ-040 Redirect to 0x42 -> fault=1, fault_pc=0x42, out_valid=0 thereafter, no further imem_addr change; a later redirect is ignored.
REQ-041 MEM_DEPTH=4 run-off (with out_ready=1):
  - pcs 0..0xC delivered;
  - fetch_pc=0x10 raises fault with fault_pc=0x10;
  - buffered entries still drain.
REQ-042 rst pulsed mid-stream with count=2 -> out_valid=0 and fault=0 at once; fetch restarts at RESET_PC.
